// File: rtl/safety_obi_mem_responder.sv
// OBI responder in front of a single-port SRAM: window/alignment decode, in-order
// responses after a fixed read latency, error responses for accesses that must not reach the SRAM.
`timescale 1ns/1ps
module safety_obi_mem_responder #(
   parameter logic [31:0] BaseAddr       = 32'h0000_0000,
   parameter int unsigned NumWords       = 4096,
   parameter int unsigned MemLatency     = 1,
   parameter int unsigned MaxOutstanding = 2,
   parameter logic [31:0] ErrVal         = 32'hBADCAB1E,
   localparam int unsigned AW            = (NumWords > 1) ? $clog2(NumWords) : 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req_i,
   output logic          gnt_o,
   input  logic [31:0]   addr_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [31:0]   wdata_i,
   output logic          rvalid_o,
   output logic [31:0]   rdata_o,
   output logic          err_o,
   output logic          sram_req_o,
   input  logic          sram_gnt_i,
   output logic          sram_we_o,
   output logic [3:0]    sram_be_o,
   output logic [AW-1:0] sram_addr_o,
   output logic [31:0]   sram_wdata_o,
   input  logic [31:0]   sram_rdata_i,
   output logic [15:0]   err_count_o
);
   localparam int unsigned CW    = $clog2(MaxOutstanding + 1);
   localparam logic [32:0] WinLo = {1'b0, BaseAddr};
   localparam logic [32:0] WinHi = WinLo + (33'(NumWords) * 33'd4);

   logic [MemLatency-1:0] r_vld;
   logic [MemLatency-1:0] r_err;
   logic [MemLatency-1:0] r_we;
   logic [CW-1:0]         r_outst;
   logic [15:0]           r_errcnt;

   logic        w_in_range;
   logic        w_bad;
   logic        w_rsp_vld;
   logic        w_slot;
   logic        w_gnt;

   // 33-bit compare keeps a window that ends at 4 GiB from wrapping to zero
   assign w_in_range = ({1'b0, addr_i} >= WinLo) && ({1'b0, addr_i} < WinHi);
   assign w_bad      = !w_in_range || (addr_i[1:0] != 2'b00) || (be_i == 4'h0);
   assign w_rsp_vld  = r_vld[MemLatency-1] && !rst_i;
   assign w_slot     = (r_outst < CW'(MaxOutstanding)) || w_rsp_vld;
   assign w_gnt      = req_i && !rst_i && w_slot && (w_bad || sram_gnt_i);

   assign gnt_o        = w_gnt;
   assign sram_req_o   = w_gnt && !w_bad;
   assign sram_we_o    = we_i;
   assign sram_be_o    = be_i;
   assign sram_wdata_o = wdata_i;
   assign sram_addr_o  = AW'((addr_i - BaseAddr) >> 2);

   assign rvalid_o    = w_rsp_vld;
   assign err_o       = w_rsp_vld && r_err[MemLatency-1];
   assign err_count_o = r_errcnt;

   always_comb begin
      rdata_o = 32'h0;
      if (w_rsp_vld) begin
         if (r_err[MemLatency-1])     rdata_o = ErrVal;
         else if (!r_we[MemLatency-1]) rdata_o = sram_rdata_i;
      end
   end

   // response pipeline tracks each grant so responses leave in grant order
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_vld <= '0;
         r_err <= '0;
         r_we  <= '0;
      end else begin
         r_vld[0] <= w_gnt;
         r_err[0] <= w_bad;
         r_we[0]  <= we_i;
         for (int i = 1; i < MemLatency; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_err[i] <= r_err[i-1];
            r_we[i]  <= r_we[i-1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_outst <= '0;
      end else begin
         case ({w_gnt, w_rsp_vld})
            2'b10:   r_outst <= r_outst + CW'(1);
            2'b01:   r_outst <= r_outst - CW'(1);
            default: r_outst <= r_outst;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_errcnt <= 16'h0;
      else if (err_o && (r_errcnt != 16'hFFFF))
         r_errcnt <= r_errcnt + 16'h1;
   end

`ifndef SYNTHESIS
   a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_i && !gnt_o) |=> (req_i && $stable(addr_i) && $stable(we_i) &&
                             $stable(be_i) && $stable(wdata_i)));
   a_outst_max: assert property (@(posedge clk_i) r_outst <= CW'(MaxOutstanding));
   a_outst_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      rvalid_o |-> (r_outst != '0));
`endif

endmodule
